// File: rtl/bfloat_pkg.sv
// Shared BF16 types, compare result codes and helpers for the argmax reducer.
package bfloat_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] mant;
   } bf16_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } argmax_state_t;

   localparam logic [1:0]  CMP_EQ    = 2'b00;
   localparam logic [1:0]  CMP_GT    = 2'b01;
   localparam logic [1:0]  CMP_LT    = 2'b10;
   localparam logic [15:0] BF16_QNAN = 16'h7FC0;

   function automatic logic is_nan(input logic [15:0] x);
      bf16_t v;
      v = x;
      return (v.exp == 8'hFF) && (v.mant != 7'd0);
   endfunction

endpackage

// File: rtl/bfloat_cmp_core.sv
// Combinational BF16 magnitude compare: code 01 when a > b, 10 when a < b, 00 when equal.
module bfloat_cmp_core
   import bfloat_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [1:0]  code
);

   bf16_t a_s;
   bf16_t b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      code = CMP_EQ;
      // +0 and -0 compare equal even though their encodings differ
      if ((a == b) || ((a[14:0] == 15'd0) && (b[14:0] == 15'd0))) begin
         code = CMP_EQ;
      end else if (a_s.sign != b_s.sign) begin
         code = a_s.sign ? CMP_LT : CMP_GT;
      end else if (!a_s.sign) begin
         code = (a[14:0] > b[14:0]) ? CMP_GT : CMP_LT;
      end else begin
         code = (a[14:0] > b[14:0]) ? CMP_LT : CMP_GT;
      end
   end

endmodule

// File: rtl/bfloat_argmax.sv
// Streaming BF16 max/argmax reducer: accumulates a vector, then holds the
// maximum, its first index, the element count and a sticky NaN flag.
module bfloat_argmax
   import bfloat_pkg::*;
#(
   parameter int N_MAX = 256,
   parameter int IDX_W = $clog2(N_MAX)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_max,
   output logic [IDX_W-1:0]   out_idx,
   output logic [IDX_W:0]     out_count,
   output logic               out_nan
);

   localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(N_MAX - 1);

   argmax_state_t    state_q, state_d;
   logic             ready_q, ready_d;
   logic             have_q, have_d;
   logic             nan_q, nan_d;
   logic [15:0]      max_q, max_d;
   logic [IDX_W-1:0] max_idx_q, max_idx_d;
   logic [IDX_W:0]   idx_q, idx_d;

   logic             out_valid_q, out_valid_d;
   logic [15:0]      out_max_q, out_max_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [IDX_W:0]   out_count_q, out_count_d;
   logic             out_nan_q, out_nan_d;

   logic [1:0] code;
   logic       beat;
   logic       elem_nan;
   logic       take;
   logic       last_beat;

   bfloat_cmp_core u_cmp (
      .a    (in_data),
      .b    (max_q),
      .code (code)
   );

   assign beat      = in_valid && ready_q;
   assign elem_nan  = is_nan(in_data);
   assign take      = beat && !elem_nan && (!have_q || (code == CMP_GT));
   assign last_beat = beat && (in_last || (idx_q == LAST_IDX));

   always_comb begin
      state_d     = state_q;
      have_d      = have_q;
      nan_d       = nan_q;
      max_d       = max_q;
      max_idx_d   = max_idx_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_max_d   = out_max_q;
      out_idx_d   = out_idx_q;
      out_count_d = out_count_q;
      out_nan_d   = out_nan_q;

      case (state_q)
         ST_IDLE, ST_ACC: begin
            if (beat) begin
               idx_d = idx_q + (IDX_W+1)'(1);
               nan_d = nan_q | elem_nan;
               if (take) begin
                  have_d    = 1'b1;
                  max_d     = in_data;
                  max_idx_d = idx_q[IDX_W-1:0];
               end
               if (last_beat) begin
                  // An all-NaN vector reports the canonical quiet NaN at index 0
                  state_d     = ST_HOLD;
                  out_valid_d = 1'b1;
                  out_max_d   = have_d ? max_d : BF16_QNAN;
                  out_idx_d   = have_d ? max_idx_d : '0;
                  out_count_d = idx_d;
                  out_nan_d   = nan_d;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               have_d      = 1'b0;
               nan_d       = 1'b0;
               max_d       = 16'h0000;
               max_idx_d   = '0;
               idx_d       = '0;
               out_valid_d = 1'b0;
               out_max_d   = 16'h0000;
               out_idx_d   = '0;
               out_count_d = '0;
               out_nan_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d != ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         have_q      <= 1'b0;
         nan_q       <= 1'b0;
         max_q       <= 16'h0000;
         max_idx_q   <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_max_q   <= 16'h0000;
         out_idx_q   <= '0;
         out_count_q <= '0;
         out_nan_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         have_q      <= have_d;
         nan_q       <= nan_d;
         max_q       <= max_d;
         max_idx_q   <= max_idx_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_max_q   <= out_max_d;
         out_idx_q   <= out_idx_d;
         out_count_q <= out_count_d;
         out_nan_q   <= out_nan_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = out_valid_q;
   assign out_max   = out_max_q;
   assign out_idx   = out_idx_q;
   assign out_count = out_count_q;
   assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_bfloat_argmax.sv
// Directed self-checking bench for bfloat_argmax, built with N_MAX=4 so the
// forced-last path is reachable with short vectors.
module tb_bfloat_argmax;

   localparam int N_MAX = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_max;
   logic [IDX_W-1:0] out_idx;
   logic [IDX_W:0]   out_count;
   logic             out_nan;

   int n_checks = 0;
   int n_fail   = 0;

   bfloat_argmax #(.N_MAX(N_MAX), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .out_count (out_count),
      .out_nan   (out_nan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one element and hold it until the DUT accepts it.
   task automatic send(input logic [15:0] d, input logic last);
      int waitc;
      waitc    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (waitc >= 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      $display("beat data=%h last=%0b", d, last);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'h0000;
   endtask

   task automatic get_result(input string tag, input logic [15:0] e_max, input logic [IDX_W-1:0] e_idx,
                             input logic [IDX_W:0] e_cnt, input logic e_nan);
      int waitc;
      waitc = 0;
      while (out_valid !== 1'b1 && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      $display("result %s max=%h idx=%0d count=%0d nan=%0b", tag, out_max, out_idx, out_count, out_nan);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_max"},   {16'd0, out_max}, {16'd0, e_max});
      check({tag, "_idx"},   {30'd0, out_idx}, {30'd0, e_idx});
      check({tag, "_count"}, {29'd0, out_count}, {29'd0, e_cnt});
      check({tag, "_nan"},   {31'd0, out_nan}, {31'd0, e_nan});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_last   = 1'b0;
      out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_max",   {16'd0, out_max}, 32'd0);
      check("rst_out_idx",   {30'd0, out_idx}, 32'd0);
      check("rst_out_count", {29'd0, out_count}, 32'd0);
      check("rst_out_nan",   {31'd0, out_nan}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // Mixed signs with latency check on the last beat
      send(16'h3F8E, 1'b0);
      send(16'h401D, 1'b0);
      check("mixed_no_early_valid", {31'd0, out_valid}, 32'd0);
      send(16'hC01D, 1'b1);
      check("mixed_latency", {31'd0, out_valid}, 32'd1);
      check("mixed_hold_ready", {31'd0, in_ready}, 32'd0);
      get_result("mixed", 16'h401D, 2'd1, 3'd4 - 3'd1, 1'b0);

      send(16'hBF99, 1'b0);
      send(16'hBFA6, 1'b0);
      send(16'hBE4C, 1'b0);
      send(16'hC013, 1'b1);
      get_result("neg", 16'hBE4C, 2'd2, 3'd4, 1'b0);

      send(16'h8000, 1'b0);
      send(16'h0000, 1'b1);
      get_result("zeros", 16'h8000, 2'd0, 3'd2, 1'b0);

      send(16'h3F80, 1'b0);
      send(16'h3F80, 1'b0);
      send(16'h3F80, 1'b1);
      get_result("ties", 16'h3F80, 2'd0, 3'd3, 1'b0);

      send(16'h7FC1, 1'b0);
      send(16'hC000, 1'b0);
      send(16'h7F80, 1'b1);
      get_result("nan_mix", 16'h7F80, 2'd2, 3'd3, 1'b1);

      send(16'hFFC1, 1'b1);
      get_result("all_nan", 16'h7FC0, 2'd0, 3'd1, 1'b1);

      // Consumer stall: junk offered while in_ready is low must be ignored
      send(16'h4080, 1'b0);
      send(16'hC2C8, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h7F00;
         in_last  = 1'b1;
         @(posedge clk); #1;
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_ready", {31'd0, in_ready}, 32'd0);
         check("stall_max",   {16'd0, out_max}, 32'h4080);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      get_result("stall", 16'h4080, 2'd0, 3'd2, 1'b0);

      // Forced last at N_MAX elements; the fifth element opens a new vector
      send(16'h3F80, 1'b0);
      send(16'h4000, 1'b0);
      send(16'h3F00, 1'b0);
      send(16'h4040, 1'b0);
      get_result("forced", 16'h4040, 2'd3, 3'd4, 1'b0);
      send(16'h4100, 1'b1);
      get_result("fifth", 16'h4100, 2'd0, 3'd1, 1'b0);

      // Reset mid-vector discards the partial result
      send(16'h4100, 1'b0);
      send(16'h3F80, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("midrst_no_result", {31'd0, out_valid}, 32'd0);
      end
      send(16'h4000, 1'b1);
      get_result("after_rst", 16'h4000, 2'd0, 3'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
